gps_tx_scheduler: RTL

Frame scheduler that shares one byte-wide UART transmitter between two frame sources: the 48-byte position/ASCII report from the GPRMC pickup stage and a 10-byte date/time report. It latches each source's frame on request and picks a winner round-robin. It then serializes the winning frame MSB-byte first through the UART transmitter's start/busy handshake and signals completion per source. It sits between the pickup/parsing logic and `uart_tx`.

---
 rtl/gps_tx_scheduler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/gps_tx_scheduler.sv
// Purpose: round-robin frame scheduler sharing one byte-wide UART between position and time frame sources; optional CR/LF terminator (GPS_TX_CRLF_EN).
// Latency: request at edge N -> grant/ISSUE at N+1 (tx_en high N+1..N+2); each byte >= 3 clocks; done one cycle after final tx_busy low.
// Backpressure: paced by the UART tx_busy handshake; a request for a source already pending or in transmission is dropped (drop pulse).
module gps_tx_scheduler #(
    parameter int POS_BYTES  = 48,
    parameter int TIME_BYTES = 10,
    parameter int GAP_CYCLES = 16,
    parameter int HS_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pos_req,
    input  logic [POS_BYTES*8-1:0]  pos_data,
    input  logic                    time_req,
    input  logic [TIME_BYTES*8-1:0] time_data,
    input  logic                    tx_busy,
    output logic [7:0]              tx_data,
    output logic                    tx_en,
    output logic                    pos_done,
    output logic                    time_done,
    output logic                    drop,
    output logic                    tx_err,
    output logic                    busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, GAP} state_t;

    localparam logic SRC_POS  = 1'b0;
    localparam logic SRC_TIME = 1'b1;

`ifdef GPS_TX_CRLF_EN
    localparam int TERM_BYTES = 2;
`else
    localparam int TERM_BYTES = 0;
`endif

    localparam logic [5:0] POS_LAST_IDX  = 6'(POS_BYTES + TERM_BYTES - 1);
    localparam logic [5:0] TIME_LAST_IDX = 6'(TIME_BYTES + TERM_BYTES - 1);

    localparam int TW = $clog2(HS_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(HS_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    state_t                  state, state_n;
    logic                    pos_pend, time_pend;
    logic [POS_BYTES*8-1:0]  pos_snap;
    logic [TIME_BYTES*8-1:0] time_snap;
    logic                    last, last_n;
    logic                    owner, owner_n;
    logic [5:0]              idx, idx_n, idx_inc, frame_last;
    logic [TW-1:0]           timer, timer_n;
    logic [GW-1:0]           gap_cnt, gap_n;
    logic                    tx_en_n, pos_done_n, time_done_n, tx_err_n;
    logic                    grant_pos, grant_time;
    logic                    ld_byte, ld_src;
    logic [5:0]              ld_idx;
    logic [7:0]              byte_sel;
    logic                    in_frame, pos_blk, time_blk;
    int unsigned             k;
    logic [POS_BYTES*8-1:0]  pos_sh;
    logic [TIME_BYTES*8-1:0] time_sh;

    assign busy       = (state != IDLE);
    assign in_frame   = (state == ISSUE) || (state == WAIT_HI) || (state == WAIT_LO);
    // A granted source is still pending during its grant cycle, so pending covers that case.
    assign pos_blk    = pos_pend  || (in_frame && owner == SRC_POS);
    assign time_blk   = time_pend || (in_frame && owner == SRC_TIME);
    assign idx_inc    = idx + 6'd1;
    assign frame_last = (owner == SRC_TIME) ? TIME_LAST_IDX : POS_LAST_IDX;

    // Request intake: latch pending flags, flag discarded requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_pend  <= 1'b0;
            time_pend <= 1'b0;
            drop      <= 1'b0;
        end else begin
            pos_pend  <= (pos_pend  & ~grant_pos)  | (pos_req  & ~pos_blk);
            time_pend <= (time_pend & ~grant_time) | (time_req & ~time_blk);
            drop      <= (pos_req & pos_blk) | (time_req & time_blk);
        end
    end

    // Snapshot registers capture frame data only for accepted requests.
    always_ff @(posedge clk) begin
        if (rst_n && pos_req && !pos_blk)
            pos_snap <= pos_data;
        if (rst_n && time_req && !time_blk)
            time_snap <= time_data;
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= SRC_TIME;
            owner     <= SRC_POS;
            idx       <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            tx_data   <= 8'h00;
            tx_en     <= 1'b0;
            pos_done  <= 1'b0;
            time_done <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            owner     <= owner_n;
            idx       <= idx_n;
            timer     <= timer_n;
            gap_cnt   <= gap_n;
            tx_en     <= tx_en_n;
            pos_done  <= pos_done_n;
            time_done <= time_done_n;
            tx_err    <= tx_err_n;
            if (ld_byte)
                tx_data <= byte_sel;
        end
    end

    // Next-state logic: arbitration in IDLE, byte handshake, gap timing.
    always_comb begin
        state_n     = state;
        last_n      = last;
        owner_n     = owner;
        idx_n       = idx;
        timer_n     = timer;
        gap_n       = gap_cnt;
        tx_en_n     = 1'b0;
        pos_done_n  = 1'b0;
        time_done_n = 1'b0;
        tx_err_n    = 1'b0;
        grant_pos   = 1'b0;
        grant_time  = 1'b0;
        ld_byte     = 1'b0;
        ld_src      = owner;
        ld_idx      = idx_inc;
        case (state)
            IDLE: begin
                if (pos_pend && (!time_pend || last == SRC_TIME))
                    grant_pos = 1'b1;
                else if (time_pend)
                    grant_time = 1'b1;
                if (grant_pos || grant_time) begin
                    owner_n = grant_time;
                    last_n  = grant_time;
                    idx_n   = 6'd0;
                    state_n = ISSUE;
                    tx_en_n = 1'b1;
                    ld_byte = 1'b1;
                    ld_src  = grant_time;
                    ld_idx  = 6'd0;
                end
            end
            ISSUE: begin
                // Timer counts clocks since tx_en rose.
                timer_n = TW'(1);
                state_n = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_n = WAIT_LO;
                end else if (timer == TIMER_LAST) begin
                    tx_err_n = 1'b1;
                    gap_n    = '0;
                    state_n  = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx == frame_last) begin
                        pos_done_n  = (owner == SRC_POS);
                        time_done_n = (owner == SRC_TIME);
                        gap_n       = '0;
                        state_n     = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        idx_n   = idx_inc;
                        state_n = ISSUE;
                        tx_en_n = 1'b1;
                        ld_byte = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_n = IDLE;
                else
                    gap_n = gap_cnt + GW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Byte mux: payload MSB-byte first, then optional CR/LF terminator.
    always_comb begin
        k        = 32'(ld_idx);
        pos_sh   = pos_snap << (k * 8);
        time_sh  = time_snap << (k * 8);
        byte_sel = 8'h00;
        if (ld_src == SRC_TIME) begin
            if (k < TIME_BYTES)
                byte_sel = time_sh[TIME_BYTES*8-1 -: 8];
`ifdef GPS_TX_CRLF_EN
            else if (k == TIME_BYTES)
                byte_sel = 8'h0D;
            else if (k == TIME_BYTES + 1)
                byte_sel = 8'h0A;
`endif
        end else begin
            if (k < POS_BYTES)
                byte_sel = pos_sh[POS_BYTES*8-1 -: 8];
`ifdef GPS_TX_CRLF_EN
            else if (k == POS_BYTES)
                byte_sel = 8'h0D;
            else if (k == POS_BYTES + 1)
                byte_sel = 8'h0A;
`endif
        end
    end

endmodule
